// File: rtl/sound_pkg.sv
// Shared codes for the sound arbiter: note codes, stage codes, source codes,
// FSM states and SFX pattern lengths.
package sound_pkg;

    typedef enum logic [3:0] {
        C        = 4'b0000,
        D        = 4'b0001,
        E        = 4'b0010,
        F        = 4'b0011,
        G        = 4'b0100,
        A        = 4'b0101,
        B        = 4'b0110,
        C_H      = 4'b0111,
        D_H      = 4'b1000,
        E_H      = 4'b1001,
        F_H      = 4'b1010,
        G_H      = 4'b1011,
        A_H      = 4'b1100,
        B_H      = 4'b1101,
        C_HIGHER = 4'b1110
    } note_e;

    typedef enum logic [2:0] {
        OPENING = 3'd0,
        STAGE1  = 3'd1,
        STAGE2  = 3'd2,
        STAGE3  = 3'd3,
        FINISH  = 3'd4
    } stage_e;

    // Numeric order doubles as priority order.
    typedef enum logic [1:0] {
        SRC_MUSIC = 2'd0,
        SRC_SHOT  = 2'd1,
        SRC_HIT   = 2'd2,
        SRC_DEATH = 2'd3
    } src_e;

    typedef enum logic {
        ST_MUSIC = 1'b0,
        ST_SFX   = 1'b1
    } state_e;

    localparam int LEN_SHOT  = 2;
    localparam int LEN_HIT   = 3;
    localparam int LEN_DEATH = 4;

endpackage

// File: rtl/sound_arbiter_if.sv
// Bundle between game logic / music sequencers (master) and the arbiter (slave).
// Inputs are level or single-cycle pulses; outputs are all registered by the arbiter.
interface sound_arbiter_if #(parameter int NUM_MUSIC = 5);
    logic [2:0]             cur_stage;
    logic [NUM_MUSIC-1:0]   music_en;
    logic [4*NUM_MUSIC-1:0] music_note;
    logic                   sfx_shot;
    logic                   sfx_hit;
    logic                   sfx_death;
    logic                   mute;
    logic                   sound_en;
    logic [3:0]             note_sel;
    logic [1:0]             active_src;
    logic                   sfx_busy;

    modport master (
        output cur_stage, music_en, music_note, sfx_shot, sfx_hit, sfx_death, mute,
        input  sound_en, note_sel, active_src, sfx_busy
    );

    modport slave (
        input  cur_stage, music_en, music_note, sfx_shot, sfx_hit, sfx_death, mute,
        output sound_en, note_sel, active_src, sfx_busy
    );
endinterface

// File: rtl/sfx_pattern_rom.sv
// Combinational SFX note table: (src, step) -> note code plus last-step flag.
// Zero latency, no flow control.
module sfx_pattern_rom
    import sound_pkg::*;
(
    input  logic [1:0] src,
    input  logic [1:0] step,
    output logic [3:0] note,
    output logic       last_step
);

    always_comb begin
        note      = C;
        last_step = 1'b1;
        case (src)
            SRC_SHOT: begin
                note      = (step == 2'd0) ? G_H : E_H;
                last_step = (step == 2'(LEN_SHOT - 1));
            end
            SRC_HIT: begin
                case (step)
                    2'd0:    note = C_H;
                    2'd1:    note = G;
                    default: note = C;
                endcase
                last_step = (step == 2'(LEN_HIT - 1));
            end
            SRC_DEATH: begin
                case (step)
                    2'd0:    note = C_H;
                    2'd1:    note = A;
                    2'd2:    note = F;
                    default: note = D;
                endcase
                last_step = (step == 2'(LEN_DEATH - 1));
            end
            default: begin
                note      = C;
                last_step = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sound_arbiter.sv
// Chooses per clock which source (stage music or shot/hit/death SFX) drives the tone generator.
// One-cycle latency from request/music inputs to registered outputs; no backpressure.
module sound_arbiter
    import sound_pkg::*;
#(
    parameter int NUM_MUSIC = 5,
    parameter int SFX_TICK  = 750_000
) (
    input logic              clk,
    input logic              reset,
    sound_arbiter_if.slave   bus
);

    localparam int             TW        = $clog2(SFX_TICK);
    localparam logic [TW-1:0]  TICK_LAST = TW'(SFX_TICK - 1);

    state_e          state_q, state_d;
    logic [1:0]      src_q, src_d;
    logic [1:0]      step_q, step_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            last_q, last_d;
    logic            en_q, en_d;
    logic [3:0]      note_q, note_d;

    logic [1:0]      req;
    logic            tick_end;
    logic            pat_end;
    logic [3:0]      rom_note;
    logic            rom_last;

    always_comb begin
        req = SRC_MUSIC;
        if (bus.sfx_death)      req = SRC_DEATH;
        else if (bus.sfx_hit)   req = SRC_HIT;
        else if (bus.sfx_shot)  req = SRC_SHOT;
    end

    // last_q caches the ROM's last-step flag for the step now playing, keeping
    // end-of-pattern detection off the ROM address path.
    assign tick_end = (timer_q == TICK_LAST);
    assign pat_end  = (state_q == ST_SFX) && last_q && tick_end;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        step_d  = step_q;
        timer_d = timer_q;
        if (req != SRC_MUSIC &&
            (state_q == ST_MUSIC || req >= src_q || pat_end)) begin
            state_d = ST_SFX;
            src_d   = req;
            step_d  = 2'd0;
            timer_d = '0;
        end else if (state_q == ST_SFX) begin
            if (pat_end) begin
                state_d = ST_MUSIC;
                src_d   = SRC_MUSIC;
                step_d  = 2'd0;
                timer_d = '0;
            end else if (tick_end) begin
                timer_d = '0;
                step_d  = step_q + 2'd1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    sfx_pattern_rom u_rom (
        .src       (src_d),
        .step      (step_d),
        .note      (rom_note),
        .last_step (rom_last)
    );

    always_comb begin
        last_d = 1'b0;
        en_d   = 1'b0;
        note_d = note_q;
        if (state_d == ST_SFX) begin
            last_d = rom_last;
            en_d   = ~bus.mute;
            note_d = rom_note;
        end else begin
            // Out-of-range stages fall through: silent, last note held.
            for (int i = 0; i < NUM_MUSIC; i++) begin
                if (bus.cur_stage == 3'(i)) begin
                    en_d   = bus.music_en[i] & ~bus.mute;
                    note_d = bus.music_note[4*i +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_MUSIC;
            src_q   <= SRC_MUSIC;
            step_q  <= 2'd0;
            timer_q <= '0;
            last_q  <= 1'b0;
            en_q    <= 1'b0;
            note_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            step_q  <= step_d;
            timer_q <= timer_d;
            last_q  <= last_d;
            en_q    <= en_d;
            note_q  <= note_d;
        end
    end

    assign bus.sound_en   = en_q;
    assign bus.note_sel   = note_q;
    assign bus.active_src = src_q;
    assign bus.sfx_busy   = (state_q == ST_SFX);

endmodule

// File: doc/sound_arbiter.md
Name: sound_arbiter

Overview:
- Owns the single tone generator and decides, every clock, which source drives its sound_en/note_sel pair.
- Sources are the per-stage background-music sequencers (OPENING, STAGE1, STAGE2, STAGE3, FINISH) and three built-in sound-effect (SFX) players: shot, hit and death.
- SFX preempt music by fixed priority. Music is chosen by cur_stage.
- Sits between the music sequencers/game FSM and the tone generator.

Parameters:
- NUM_MUSIC, 5, number of music sources; source i is played when cur_stage == i.
- SFX_TICK, 750_000, length of one SFX note step in clk cycles (must be >= 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cur_stage  in  3  game stage code (0 OPENING … 4 FINISH)
- music_en  in  NUM_MUSIC  sound_en of each music sequencer; bit i belongs to source i
- music_note  in  4*NUM_MUSIC  note_sel of each sequencer; source i occupies bits [4i+3:4i]
- sfx_shot  in  1  one-cycle request pulse
- sfx_hit  in  1  one-cycle request pulse
- sfx_death  in  1  one-cycle request pulse
- mute  in  1  forces the tone generator silent
- sound_en  out  1  tone generator enable
- note_sel  out  4  tone generator note code
- active_src  out  2  current owner: 0 music, 1 shot, 2 hit, 3 death
- sfx_busy  out  1  high while any SFX pattern is playing

Behaviour:
- Reset (reset=0, asynchronous): sound_en=0, note_sel=0, active_src=0, sfx_busy=0, state=MUSIC, step=0, timer=0.
- All outputs are registered. A request sampled at edge N is visible on the outputs after edge N.
- Priority: death(3) > hit(2) > shot(1) > music(0). When several pulses arrive in the same cycle, the highest one wins.
- State MUSIC:
  - cur_stage < NUM_MUSIC: sound_en = music_en[cur_stage], note_sel = music_note slice for cur_stage.
  - cur_stage >= NUM_MUSIC: sound_en=0 and note_sel holds its last value.
  - A pulse moves the FSM to SFX with active_src set to the request, step=0, timer=0.
- State SFX:
  - sound_en=1; note_sel comes from the pattern ROM indexed by (active_src, step).
  - timer counts 0..SFX_TICK-1. At SFX_TICK-1 it clears and step increments.
  - After the last step's final cycle the FSM returns to MUSIC, and active_src and sfx_busy clear on that same edge.
- Patterns (note codes):
  - shot: G_H(1011), E_H(1001); 2 steps.
  - hit: C_H(0111), G(0100), C(0000); 3 steps.
  - death: C_H(0111), A(0101), F(0011), D(0001); 4 steps.
- Preemption during SFX:
  - A request of higher priority restarts immediately with the new pattern at step 0, timer 0.
  - A request of equal priority restarts the current pattern at step 0.
  - A request of lower priority is dropped; no queuing.
- A request arriving on the last cycle of a pattern starts that pattern directly, with no MUSIC cycle in between.
- mute=1 forces sound_en=0 in both states. The FSM, timer and note_sel keep advancing, so unmuting resumes at the correct position.
- A cur_stage change during SFX has no effect until the FSM returns to MUSIC. Music then follows the new stage.
- sfx_busy = (state == SFX).
- timer is wide enough for SFX_TICK-1 ($clog2). step is 2 bits. The arbiter does not gate the music sequencers' counters; they run independently.

Decomposition:
- Package sound_pkg holds:
  - note code constants C…C_HIGHER (0000…1110);
  - stage codes OPENING…FINISH;
  - source codes SRC_MUSIC/SRC_SHOT/SRC_HIT/SRC_DEATH;
  - per-SFX pattern lengths.
- One sub-module, sfx_pattern_rom: combinational, (src[1:0], step[1:0]) -> note[3:0], last_step.
- The FSM, timer and output registers stay in sound_arbiter.

Test Plan:
All scenarios use SFX_TICK=4 and NUM_MUSIC=5.
- Reset, then cur_stage=3, music_en=5'b01000, note slice 3 = 0101 -> one edge later sound_en=1, note_sel=0101, active_src=0, sfx_busy=0.
- Pulse sfx_shot for one cycle -> next edge: note_sel=1011 for 4 cycles, then 1001 for 4 cycles, then back to music; sfx_busy high for exactly 8 cycles.
- sfx_shot, then 2 cycles later sfx_death -> note_sel jumps to 0111 and active_src=3. Full 16-cycle death pattern plays; a sfx_hit during it is ignored (active_src stays 3).
- sfx_shot, sfx_hit and sfx_death pulsed in the same cycle -> active_src=3, note sequence 0111,0101,0011,0001 with 4 cycles each.
- mute=1 during the hit pattern -> sound_en=0 while note_sel still steps 0111→0100. Releasing mute mid-step 1 -> sound_en=1, note_sel=0100.
- Drive reset low mid-death-pattern, release it; separately set cur_stage=6 -> outputs return to reset values immediately (asynchronously); the FSM resumes in MUSIC; cur_stage=6 gives sound_en=0.
